debounce_detect: RTL and testbench

DEBOUNCE_DETECT -- requirements
Module: debounce_detect

---
 rtl/debounce_detect.sv | 111 +++++++++++
 tb/tb_debounce_detect.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_detect.sv
// Debounces a synchronized input and counts accepted presses, with sticky wrap flag.
// Latency: level/pulse/count update on the STABLE_CYCLES-th consecutive sample at the new level.
// No backpressure: samples sync_in every cycle; pulses are single-cycle and not held.
module debounce_detect #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_in,
  input  logic                 clear,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] press_count,
  output logic                 overflow
);

  // Stable counter only ever holds 1..STABLE_CYCLES-1, so clog2 bits suffice.
  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] stable_cnt;
  logic          rise_now;

  // A rise is accepted on the edge that completes the high-side check.
  assign rise_now = (state == CHK_HIGH) && sync_in && (stable_cnt == LAST);

  // Debounce FSM with registered level and single-cycle edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOW;
      stable_cnt <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        LOW: begin
          if (sync_in) begin
            state      <= CHK_HIGH;
            stable_cnt <= SW'(1);
          end
        end
        CHK_HIGH: begin
          if (!sync_in) begin
            state      <= LOW;
            stable_cnt <= '0;
          end else if (stable_cnt == LAST) begin
            state      <= HIGH;
            stable_cnt <= '0;
            level_out  <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end
        HIGH: begin
          if (!sync_in) begin
            state      <= CHK_LOW;
            stable_cnt <= SW'(1);
          end
        end
        CHK_LOW: begin
          if (sync_in) begin
            state      <= HIGH;
            stable_cnt <= '0;
          end else if (stable_cnt == LAST) begin
            state      <= LOW;
            stable_cnt <= '0;
            level_out  <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end
        default: begin
          state      <= LOW;
          stable_cnt <= '0;
        end
      endcase
    end
  end

  // Press counter with sticky wrap flag; clear wins over a same-edge rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      press_count <= '0;
      overflow    <= 1'b0;
    end else if (rise_now) begin
      press_count <= press_count + CNT_WIDTH'(1);
      if (&press_count) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_debounce_detect.sv
module tb_debounce_detect;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync_in;
  logic       clear;
  logic       level_a, rise_a, fall_a, ovf_a;
  logic [7:0] cnt_a;
  logic       level_b, rise_b, fall_b, ovf_b;
  logic [1:0] cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debounce_detect #(.STABLE_CYCLES(S), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .sync_in(sync_in), .clear(clear),
    .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .press_count(cnt_a), .overflow(ovf_a)
  );

  debounce_detect #(.STABLE_CYCLES(S), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .sync_in(sync_in), .clear(clear),
    .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .press_count(cnt_b), .overflow(ovf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the level flips when the last S samples since reset all
  // disagree with the current level; presses are counted as an unbounded
  // integer since the last clear, and each counter width is derived from it.
  bit hist[$];
  bit m_level = 0, m_rise = 0, m_fall = 0;
  int m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    bit flip;
    if (rst) begin
      hist.delete();
      m_level = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
    end else begin
      hist.push_back(sync_in);
      if (hist.size() > S) void'(hist.pop_front());
      flip = (hist.size() == S);
      foreach (hist[i]) if (hist[i] == m_level) flip = 0;
      m_rise = flip && !m_level;
      m_fall = flip && m_level;
      if (flip) m_level = !m_level;
      if (clear) m_cnt = 0;
      else if (m_rise) m_cnt++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_level_a", level_a, m_level);
    chk("m_rise_a", rise_a, m_rise);
    chk("m_fall_a", fall_a, m_fall);
    chk("m_cnt_a", cnt_a, m_cnt % 256);
    chk("m_ovf_a", ovf_a, m_cnt >= 256);
    chk("m_level_b", level_b, m_level);
    chk("m_cnt_b", cnt_b, m_cnt % 4);
    chk("m_ovf_b", ovf_b, m_cnt >= 4);
    chk("pulse_excl", rise_a & fall_a, 0);
  end

  initial begin
    rst = 1'b1; sync_in = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", level_a, 0);
    chk("rst_rise", rise_a, 0);
    chk("rst_fall", fall_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_ovf", ovf_b, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Glitch from LOW: three high samples are not enough.
    sync_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("glitch_lo_level", level_a, 0);
      chk("glitch_lo_rise", rise_a, 0);
    end
    sync_in = 1'b0;
    @(negedge clk);
    chk("glitch_lo_level_end", level_a, 0);
    chk("glitch_lo_cnt", cnt_a, 0);
    repeat (2) @(negedge clk);

    // Clean press held for 10 cycles.
    sync_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("press_level", level_a, (i >= 4) ? 1 : 0);
      chk("press_rise", rise_a, (i == 4) ? 1 : 0);
      chk("press_cnt", cnt_a, (i >= 4) ? 1 : 0);
    end

    // Glitch from HIGH: three low samples then back high.
    sync_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) sync_in = 1'b1;
      @(negedge clk);
      chk("glitch_hi_level", level_a, 1);
      chk("glitch_hi_fall", fall_a, 0);
    end

    // Release held for 6 cycles.
    sync_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("rel_level", level_a, (i < 4) ? 1 : 0);
      chk("rel_fall", fall_a, (i == 4) ? 1 : 0);
      chk("rel_cnt", cnt_a, 1);
    end

    // Presses 2..5 on the 2-bit counter: 2,3,0(wrap),1 with sticky overflow.
    for (int p = 2; p <= 5; p++) begin
      sync_in = 1'b1;
      repeat (4) @(negedge clk);
      chk("ovf_cnt_b", cnt_b, p % 4);
      chk("ovf_flag_b", ovf_b, (p >= 4) ? 1 : 0);
      sync_in = 1'b0;
      repeat (5) @(negedge clk);
    end
    chk("ovf_cnt_a", cnt_a, 5);

    // Clear on the same edge as an accepted rise.
    sync_in = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_rise", rise_a, 1);
    chk("clr_level", level_a, 1);
    chk("clr_cnt_a", cnt_a, 0);
    chk("clr_ovf_b", ovf_b, 0);
    @(negedge clk);
    chk("clr_cnt_after", cnt_a, 0);
    chk("clr_level_after", level_a, 1);
    sync_in = 1'b0;
    repeat (5) @(negedge clk);
    sync_in = 1'b1;
    repeat (5) @(negedge clk);
    sync_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_cnt", cnt_a, 1);

    // Async reset in the middle of a high-side check.
    sync_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_level", level_a, 0);
    chk("arst_cnt", cnt_a, 0);
    chk("arst_rise", rise_a, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("post_rst_rise", rise_a, (i == 4) ? 1 : 0);
      chk("post_rst_cnt", cnt_a, (i == 4) ? 1 : 0);
    end

    // Randomized runs of varying length with occasional clears.
    for (int k = 0; k < 600; k++) begin
      int len;
      sync_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        clear = ($urandom_range(0, 40) == 0);
        @(negedge clk);
      end
    end
    clear = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
